// File: rtl/inst_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_fifo_pkg
// Description : Shared widths and entry layout for the instruction queue.
//               An entry is packed as {pc, inst, adel}, with pc in the MSBs.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_fifo_pkg;

  localparam int INST_W       = 32;
  localparam int PC_W         = 32;
  localparam int FIFO_ENTRY_W = PC_W + INST_W + 1;  // 65

  // Field positions inside one packed entry
  localparam int ENTRY_ADEL_BIT = 0;
  localparam int ENTRY_INST_LSB = 1;
  localparam int ENTRY_PC_LSB   = ENTRY_INST_LSB + INST_W;  // 33

  // Build one storage word from its fields
  function automatic logic [FIFO_ENTRY_W-1:0] pack_entry(
    input logic [PC_W-1:0]   pc,
    input logic [INST_W-1:0] inst,
    input logic              adel
  );
    return {pc, inst, adel};
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_fifo_if
// Description : Fetch-push, issue-pop and controller signals of the
//               instruction queue. The master side is the pipeline
//               (fetch, issue and controller); the slave side is the queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_fifo_if #(
  parameter int PTR_W = 4
);

  logic              fifo_flush;
  logic              issue_stall;
  logic [1:0]        issue_count;

  logic              push_valid_1;
  logic [31:0]       push_pc_1;
  logic [31:0]       push_inst_1;
  logic              push_adel_1;
  logic              push_valid_2;
  logic [31:0]       push_pc_2;
  logic [31:0]       push_inst_2;
  logic              push_adel_2;

  logic              head_valid_1;
  logic [31:0]       head_pc_1;
  logic [31:0]       head_inst_1;
  logic              head_adel_1;
  logic              head_valid_2;
  logic [31:0]       head_pc_2;
  logic [31:0]       head_inst_2;
  logic              head_adel_2;

  logic              fifo_stall_req;
  logic              fifo_empty;
  logic [PTR_W:0]    fifo_count;

  modport master (
    output fifo_flush, issue_stall, issue_count,
    output push_valid_1, push_pc_1, push_inst_1, push_adel_1,
    output push_valid_2, push_pc_2, push_inst_2, push_adel_2,
    input  head_valid_1, head_pc_1, head_inst_1, head_adel_1,
    input  head_valid_2, head_pc_2, head_inst_2, head_adel_2,
    input  fifo_stall_req, fifo_empty, fifo_count
  );

  modport slave (
    input  fifo_flush, issue_stall, issue_count,
    input  push_valid_1, push_pc_1, push_inst_1, push_adel_1,
    input  push_valid_2, push_pc_2, push_inst_2, push_adel_2,
    output head_valid_1, head_pc_1, head_inst_1, head_adel_1,
    output head_valid_2, head_pc_2, head_inst_2, head_adel_2,
    output fifo_stall_req, fifo_empty, fifo_count
  );

endinterface
`default_nettype wire

// File: rtl/inst_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : inst_fifo_mem
// Description : DEPTH x FIFO_ENTRY_W register array with two write ports and
//               two asynchronous read ports. Storage is never reset. The two
//               write addresses are always distinct in use (wr_ptr, wr_ptr+1).
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fifo_mem
  import inst_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  wire logic                    clk,
  input  wire logic                    wr_en_1,
  input  wire logic [PTR_W-1:0]        wr_addr_1,
  input  wire logic [FIFO_ENTRY_W-1:0] wr_data_1,
  input  wire logic                    wr_en_2,
  input  wire logic [PTR_W-1:0]        wr_addr_2,
  input  wire logic [FIFO_ENTRY_W-1:0] wr_data_2,
  input  wire logic [PTR_W-1:0]        rd_addr_1,
  output logic      [FIFO_ENTRY_W-1:0] rd_data_1,
  input  wire logic [PTR_W-1:0]        rd_addr_2,
  output logic      [FIFO_ENTRY_W-1:0] rd_data_2
);

  logic [DEPTH-1:0][FIFO_ENTRY_W-1:0] entries;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [FIFO_ENTRY_W-1:0] entry_d;
    logic [FIFO_ENTRY_W-1:0] entry_q;

    // Select the write port addressing this entry, else hold
    always_comb begin
      entry_d = entry_q;
      if (wr_en_1 && (wr_addr_1 == PTR_W'(i))) entry_d = wr_data_1;
      if (wr_en_2 && (wr_addr_2 == PTR_W'(i))) entry_d = wr_data_2;
    end

    // Storage register, intentionally without reset
    always_ff @(posedge clk) begin
      entry_q <= entry_d;
    end

    assign entries[i] = entry_q;
  end

  // Asynchronous read ports
  always_comb begin
    rd_data_1 = entries[rd_addr_1];
    rd_data_2 = entries[rd_addr_2];
  end

endmodule
`default_nettype wire

// File: rtl/inst_fifo.sv
`default_nettype none
// ============================================================================
// Module      : inst_fifo
// Description : Dual-push / dual-pop instruction queue between fetch and
//               issue. Requests a fetch stall once fewer than two entries are
//               free; a flush drops all contents and same-cycle pushes.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fifo
  import inst_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  wire logic  clk,
  input  wire logic  rst,
  inst_fifo_if.slave bus
);

  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic                    stall_req;
  logic                    accept;
  logic                    we_1, we_2;
  logic [1:0]              n_push;
  logic [1:0]              n_pop_req;
  logic [1:0]              n_pop;
  logic [FIFO_ENTRY_W-1:0] rd_data_1, rd_data_2;

  inst_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk       (clk),
    .wr_en_1   (we_1),
    .wr_addr_1 (wr_ptr_q),
    .wr_data_1 (pack_entry(bus.push_pc_1, bus.push_inst_1, bus.push_adel_1)),
    .wr_en_2   (we_2),
    .wr_addr_2 (wr_ptr_q + PTR_W'(1)),
    .wr_data_2 (pack_entry(bus.push_pc_2, bus.push_inst_2, bus.push_adel_2)),
    .rd_addr_1 (rd_ptr_q),
    .rd_data_1 (rd_data_1),
    .rd_addr_2 (rd_ptr_q + PTR_W'(1)),
    .rd_data_2 (rd_data_2)
  );

  // Push acceptance, clamped pop and next pointer/count state
  always_comb begin
    stall_req = (count_q >= CNT_W'(DEPTH - 1));
    accept    = !stall_req && !bus.fifo_flush;
    // Slot 2 is only honoured alongside slot 1
    we_1      = accept && bus.push_valid_1;
    we_2      = accept && bus.push_valid_1 && bus.push_valid_2;
    n_push    = {1'b0, we_1} + {1'b0, we_2};

    n_pop_req = bus.issue_stall ? 2'd0 : bus.issue_count;
    n_pop     = (CNT_W'(n_pop_req) > count_q) ? count_q[1:0] : n_pop_req;

    rd_ptr_d  = rd_ptr_q + PTR_W'(n_pop);
    wr_ptr_d  = wr_ptr_q + PTR_W'(n_push);
    count_d   = count_q + CNT_W'(n_push) - CNT_W'(n_pop);

    if (bus.fifo_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head outputs from registered state, data zeroed when not valid
  always_comb begin
    bus.head_valid_1   = (count_q >= CNT_W'(1));
    bus.head_valid_2   = (count_q >= CNT_W'(2));
    bus.head_pc_1      = '0;
    bus.head_inst_1    = '0;
    bus.head_adel_1    = 1'b0;
    bus.head_pc_2      = '0;
    bus.head_inst_2    = '0;
    bus.head_adel_2    = 1'b0;
    if (bus.head_valid_1) begin
      bus.head_pc_1   = rd_data_1[ENTRY_PC_LSB +: PC_W];
      bus.head_inst_1 = rd_data_1[ENTRY_INST_LSB +: INST_W];
      bus.head_adel_1 = rd_data_1[ENTRY_ADEL_BIT];
    end
    if (bus.head_valid_2) begin
      bus.head_pc_2   = rd_data_2[ENTRY_PC_LSB +: PC_W];
      bus.head_inst_2 = rd_data_2[ENTRY_INST_LSB +: INST_W];
      bus.head_adel_2 = rd_data_2[ENTRY_ADEL_BIT];
    end
    bus.fifo_stall_req = stall_req;
    bus.fifo_empty     = (count_q == '0);
    bus.fifo_count     = count_q;
  end

`ifndef SYNTHESIS
  // Flag illegal push slot usage and pops beyond current occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_slot2_alone : assert (!(bus.push_valid_2 && !bus.push_valid_1));
      a_pop_range   : assert (bus.issue_stall || bus.fifo_flush ||
                              ((bus.issue_count != 2'd3) &&
                               (CNT_W'(bus.issue_count) <= count_q)));
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/inst_fifo.md
Name: inst_fifo

Overview:
- Decoupling instruction queue between the fetch stage and the dual-issue stage.
- Fetch pushes up to two instructions per cycle; issue pops 0, 1 or 2 per cycle from the head.
- Produces fifo_stall_req, which drives pc_stall in the pipeline controller. Consumes fifo_flush (branch or exception redirect) and issue_stall from that controller.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 4.
- PTR_W, 4, log2(DEPTH); pointer width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- fifo_flush  in  1  discard all entries and all same-cycle pushes
- issue_stall  in  1  issue stage frozen; no pop this cycle
- issue_count  in  2  entries consumed by issue this cycle (0..2)
- push_valid_1  in  1  slot 1 carries an instruction
- push_pc_1  in  32  PC of slot 1
- push_inst_1  in  32  instruction word of slot 1
- push_adel_1  in  1  fetch address-error flag of slot 1
- push_valid_2  in  1  slot 2 carries an instruction; legal only with push_valid_1
- push_pc_2  in  32  PC of slot 2
- push_inst_2  in  32  instruction word of slot 2
- push_adel_2  in  1  fetch address-error flag of slot 2
- head_valid_1  out  1  oldest entry present
- head_pc_1  out  32  PC of the oldest entry
- head_inst_1  out  32  instruction word of the oldest entry
- head_adel_1  out  1  address-error flag of the oldest entry
- head_valid_2  out  1  second-oldest entry present
- head_pc_2  out  32  PC of the second-oldest entry
- head_inst_2  out  32  instruction word of the second-oldest entry
- head_adel_2  out  1  address-error flag of the second-oldest entry
- fifo_stall_req  out  1  fewer than two free entries
- fifo_empty  out  1  count == 0
- fifo_count  out  PTR_W+1  occupancy

Behaviour:
- **State:** rd_ptr and wr_ptr (PTR_W bits each, wrap modulo DEPTH), count (PTR_W+1 bits), DEPTH entries of {pc, inst, adel}.
- **Reset and flush:** on rst or fifo_flush, all three registers clear to 0 at the next edge. Reset values: head_valid_* = 0, head data = 0, fifo_stall_req = 0, fifo_empty = 1, fifo_count = 0. Entry storage is not cleared.
- **Flush priority:** fifo_flush overrides push and pop in the same cycle. Pushes arriving in a flush cycle are dropped.
- **Stall request:** fifo_stall_req = (count >= DEPTH-1). It is a function of registered count only; no combinational path from the issue inputs.
- **Push acceptance:**
  - n_push = push_valid_1 + push_valid_2, accepted only when fifo_stall_req = 0 and fifo_flush = 0.
  - While fifo_stall_req = 1, all pushes are ignored; fetch holds them under pc_stall.
  - Slot 1 is written at wr_ptr, slot 2 at wr_ptr+1 (wrapping).
  - push_valid_2 without push_valid_1 is illegal: simulation assertion; RTL ignores slot 2.
- **Pop:**
  - n_pop = issue_stall ? 0 : issue_count, clamped to count.
  - issue_count = 3, or issue_count > count, fires a simulation assertion.
  - rd_ptr advances by n_pop.
- **Update:** count_next = count + n_push - n_pop, with both terms computed on current-cycle state. Simultaneous push and pop is legal at any occupancy, including full (count = DEPTH, no push accepted) and empty (n_pop forced to 0).
- **Head outputs (combinational from registered state, zero latency):**
  - head_valid_1 = (count >= 1); head_valid_2 = (count >= 2).
  - Data comes from entries rd_ptr and rd_ptr+1 (wrapping), forced to 0 when the corresponding valid is low.
- **Latency:** an entry pushed at edge N is visible on the head at cycle N+1 if the queue was empty. There is no bypass of same-cycle push to the head.
- **Wrap-around:** pointers wrap with no special handling. Slot 2 of a push or pop may straddle index DEPTH-1 → 0.
- **Ordering:** program order is preserved; slot 1 is always older than slot 2.

Decomposition:
- **Shared header (global defines):** INST_W = 32, PC_W = 32, FIFO_ENTRY_W = 65 (pc|inst|adel), and the field bit positions inside an entry.
- **Sub-module inst_fifo_mem:** DEPTH x FIFO_ENTRY_W register array.
  - Two write ports (addr/data/en), two asynchronous read ports.
  - No reset on storage.
- **inst_fifo proper:** pointers, count, acceptance/pop logic, output gating.

Test Plan:
- **Reset, then single pushes:** after rst, push pc 0xBFC00000 and 0xBFC00004 (two single pushes) → head_valid_1/2 = 1, head_pc_1 = 0xBFC00000, fifo_count = 2, fifo_empty = 0.
- **Fill:** dual pushes every cycle from empty, no pops → fifo_stall_req rises when count reaches 15 (after 8 dual pushes, count = 16). Further pushes are ignored; count stays 16.
- **Full with mixed traffic:** at count = 16, issue_count = 2 with a dual push → count = 14, stall_req drops next cycle. Then a dual push plus issue_count = 1 → count = 15.
- **Wrap straddle:** with rd_ptr = wr_ptr = 15 and count = 0, dual push A, B → A is stored at index 15 and B at index 0. head_pc_1 = A, head_pc_2 = B; popping 2 gives empty with rd_ptr = 1.
- **Flush priority:** count = 9 with dual push, issue_count = 2 and fifo_flush = 1 in the same cycle → next cycle count = 0, head_valid_1 = 0, head_pc_1 = 0.
- **Stall masking:** count = 3 with issue_stall = 1 and issue_count = 2 → no pop, count unchanged, heads unchanged.
